// File: rtl/axis2axil_pkg.sv
// Shared definitions for the AXIS byte-stream to AXI4-Lite bridge.
// Holds the command and status codes, the bridge FSM state encoding and the status merge helper.
// Ports: none (package).
package axis2axil_pkg;

   localparam logic [7:0] CMD_NOP     = 8'h00;
   localparam logic [7:0] CMD_READ    = 8'h01;
   localparam logic [7:0] CMD_WRITE   = 8'h02;

   localparam logic [7:0] STS_OK      = 8'h00;
   localparam logic [7:0] STS_ILLEGAL = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_ADDR,
      ST_WDATA,
      ST_WAXI,
      ST_RAXI,
      ST_RTX,
      ST_STATUS
   } state_t;

   // States in which the RX byte port accepts data.
   function automatic logic rx_state(input state_t s);
      return (s == ST_IDLE) || (s == ST_LEN) || (s == ST_ADDR) || (s == ST_WDATA);
   endfunction

   // Keep the first non-OKAY response of a frame; later responses never overwrite it.
   function automatic logic [7:0] merge_sts(input logic [7:0] sts, input logic [1:0] resp);
      return ((sts == STS_OK) && (resp != 2'b00)) ? {6'b0, resp} : sts;
   endfunction

endpackage

// File: rtl/axis_word_ser.sv
// Purpose: serialise one parallel word onto an 8-bit AXIS stream, least-significant byte first.
// Latency: first byte valid the cycle after load; one byte per cycle while tready is high.
// Backpressure: tdata/tvalid held while tready is low; load is only honoured when busy is low.
// Ports: clk, rst (async, active-high), load/word (parallel input), busy, tdata/tvalid/tready (byte output).
module axis_word_ser #(
   parameter int DATA_BYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [8*DATA_BYTES-1:0] word,
   output logic                    busy,
   output logic [7:0]              tdata,
   output logic                    tvalid,
   input  logic                    tready
);

   logic [8*DATA_BYTES-1:0] sreg;
   logic [3:0]              cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (load && !busy) begin
         sreg <= word;
         cnt  <= 4'(DATA_BYTES);
      end else if (tvalid && tready) begin
         sreg <= sreg >> 8;
         cnt  <= cnt - 4'd1;
      end
   end

   assign busy   = (cnt != 4'd0);
   assign tvalid = busy;
   assign tdata  = sreg[7:0];

endmodule

// File: rtl/axis2axil_bridge.sv
// Purpose: decode CMD/LEN/ADDR[/DATA] byte frames into AXI4-Lite bursts and answer with read data plus a status byte.
// Latency: last RX byte of a write word to awvalid = 2 cycles; last ADDR byte to arvalid = 2 cycles.
// Backpressure: RX tready (registered, from FSM state) is low while AXI is outstanding or TX is busy; TX held until tready.
// Ports: aclk, areset (async, active-high), s_axis_* RX bytes, m_axis_* TX bytes,
//        m_axi_aw*/w*/b* write channels, m_axi_ar*/r* read channels (one transaction outstanding).
module axis2axil_bridge
   import axis2axil_pkg::*;
#(
   parameter int ADDR_BYTES = 2,
   parameter int DATA_BYTES = 4
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [7:0]              s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [7:0]              m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [31:0]             m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [8*DATA_BYTES-1:0] m_axi_wdata,
   output logic [DATA_BYTES-1:0]   m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [31:0]             m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [8*DATA_BYTES-1:0] m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   localparam int         AW        = 8 * ADDR_BYTES;
   localparam int         DW        = 8 * DATA_BYTES;
   localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);
   localparam logic [2:0] DATA_LAST = 3'(DATA_BYTES - 1);

   state_t          state, state_nx;
   logic [7:0]      len, word_cnt, sts;
   logic [2:0]      byte_cnt;
   logic [AW-1:0]   addr_cur;   // address of the current word, wraps within ADDR_BYTES
   logic [DW-1:0]   wbuf;
   logic            is_write;
   logic            issued;     // AXI request for the current word already launched
   logic            rx_hs, b_hs, r_hs, last_word;
   logic            ser_load, ser_busy, ser_tvalid, ser_tready;
   logic [7:0]      ser_tdata;

   assign rx_hs     = s_axis_tvalid && s_axis_tready;
   assign b_hs      = m_axi_bvalid && m_axi_bready;
   assign r_hs      = m_axi_rvalid && m_axi_rready;
   assign last_word = (word_cnt == len);

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;

   // State register.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (rx_hs) begin
                       if (s_axis_tdata == CMD_READ || s_axis_tdata == CMD_WRITE) state_nx = ST_LEN;
                       else if (s_axis_tdata != CMD_NOP)                          state_nx = ST_STATUS;
                    end
         ST_LEN:    if (rx_hs) state_nx = ST_ADDR;
         ST_ADDR:   if (rx_hs && byte_cnt == ADDR_LAST) state_nx = is_write ? ST_WDATA : ST_RAXI;
         ST_WDATA:  if (rx_hs && byte_cnt == DATA_LAST) state_nx = ST_WAXI;
         ST_WAXI:   if (b_hs) state_nx = last_word ? ST_STATUS : ST_WDATA;
         ST_RAXI:   if (r_hs) state_nx = ST_RTX;
         ST_RTX:    if (!ser_busy) state_nx = last_word ? ST_STATUS : ST_RAXI;
         ST_STATUS: if (m_axis_tready) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Output decode: TX is the serializer except in STATUS, where the status byte is driven directly.
   always_comb begin
      ser_load      = (state == ST_RAXI) && r_hs;
      ser_tready    = m_axis_tready && (state != ST_STATUS);
      m_axis_tvalid = (state == ST_STATUS) || ser_tvalid;
      m_axis_tdata  = (state == ST_STATUS) ? sts : ser_tdata;
   end

   // Datapath and registered AXI/RX control.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         s_axis_tready <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         len           <= '0;
         word_cnt      <= '0;
         byte_cnt      <= '0;
         addr_cur      <= '0;
         wbuf          <= '0;
         sts           <= STS_OK;
         is_write      <= 1'b0;
         issued        <= 1'b0;
      end else begin
         // Registered copy of the RX-accepting state decode, so tready is 0 throughout reset.
         s_axis_tready <= rx_state(state_nx);
         case (state)
            ST_IDLE: if (rx_hs) begin
               is_write <= (s_axis_tdata == CMD_WRITE);
               sts      <= (s_axis_tdata <= CMD_WRITE) ? STS_OK : STS_ILLEGAL;
               word_cnt <= '0;
               byte_cnt <= '0;
            end
            ST_LEN: if (rx_hs) begin
               len      <= s_axis_tdata;
               byte_cnt <= '0;
            end
            ST_ADDR: if (rx_hs) begin
               // Little-endian: shift in from the top so the first byte ends up in the LSBs.
               addr_cur <= AW'({s_axis_tdata, addr_cur} >> 8);
               byte_cnt <= (byte_cnt == ADDR_LAST) ? 3'd0 : byte_cnt + 3'd1;
               issued   <= 1'b0;
            end
            ST_WDATA: if (rx_hs) begin
               wbuf     <= DW'({s_axis_tdata, wbuf} >> 8);
               byte_cnt <= (byte_cnt == DATA_LAST) ? 3'd0 : byte_cnt + 3'd1;
            end
            ST_WAXI: begin
               if (!issued) begin
                  m_axi_awaddr  <= 32'(addr_cur);
                  m_axi_wdata   <= wbuf;
                  m_axi_wstrb   <= '1;
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  m_axi_bready  <= 1'b1;
                  issued        <= 1'b1;
               end else begin
                  if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                  if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
                  if (b_hs) begin
                     m_axi_bready <= 1'b0;
                     sts          <= merge_sts(sts, m_axi_bresp);
                     issued       <= 1'b0;
                     if (!last_word) begin
                        word_cnt <= word_cnt + 8'd1;
                        addr_cur <= addr_cur + AW'(DATA_BYTES);
                     end
                  end
               end
            end
            ST_RAXI: begin
               if (!issued) begin
                  m_axi_araddr  <= 32'(addr_cur);
                  m_axi_arvalid <= 1'b1;
                  m_axi_rready  <= 1'b1;
                  issued        <= 1'b1;
               end else begin
                  if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;
                  if (r_hs) begin
                     m_axi_rready <= 1'b0;
                     sts          <= merge_sts(sts, m_axi_rresp);
                     issued       <= 1'b0;
                  end
               end
            end
            ST_RTX: if (!ser_busy && !last_word) begin
               word_cnt <= word_cnt + 8'd1;
               addr_cur <= addr_cur + AW'(DATA_BYTES);
            end
            default: ;
         endcase
      end
   end

   axis_word_ser #(
      .DATA_BYTES (DATA_BYTES)
   ) u_ser (
      .clk    (aclk),
      .rst    (areset),
      .load   (ser_load),
      .word   (m_axi_rdata),
      .busy   (ser_busy),
      .tdata  (ser_tdata),
      .tvalid (ser_tvalid),
      .tready (ser_tready)
   );

endmodule
